// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed programmable access latency.
// It does byte-lane write merging and flags out-of-range addresses.
module mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 17,
    parameter int LATENCY       = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_be,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int INDEX_WIDTH = ADDRESS_WIDTH - 2;
    localparam int DEPTH       = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              count_q, count_d;
    logic                    we_q, we_d;
    logic                    oor_q, oor_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   old_q;
    logic [DATA_WIDTH-1:0]   merged;
    logic                    accept;
    logic                    access;
    logic                    mem_we;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    assign accept = (state_q == IDLE) && req_valid;
    assign access = (state_q == BUSY) && (count_q == 4'd0);
    assign mem_we = access && we_q && !oor_q && (|be_q);

    // The old word is fetched at accept time so the merge sees it even with LATENCY=1.
    always_ff @(posedge CLK) begin
        if (accept) begin
            old_q <= mem[req_addr[ADDRESS_WIDTH-1:2]];
        end
        if (mem_we) begin
            mem[index_q] <= merged;
        end
    end

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_merge
        if (gi / 8 < 4) begin : g_lane
            assign merged[gi] = be_q[gi/8] ? wdata_q[gi] : old_q[gi];
        end else begin : g_keep
            assign merged[gi] = old_q[gi];
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        we_d         = we_q;
        oor_d        = oor_q;
        index_d      = index_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    oor_d   = (req_addr >> ADDRESS_WIDTH) != 32'd0;
                    index_d = req_addr[ADDRESS_WIDTH-1:2];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    count_d = 4'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q == 4'd0) begin
                    state_d    = RESP;
                    resp_err_d = oor_q;
                    if (oor_q) begin
                        resp_rdata_d = '0;
                    end else if (we_q) begin
                        resp_rdata_d = merged;
                    end else begin
                        resp_rdata_d = old_q;
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            count_q      <= 4'd0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            index_q      <= '0;
            wdata_q      <= '0;
            be_q         <= 4'd0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            index_q      <= index_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 32, word width.
- ADDRESS_WIDTH, default 17, byte-address bits backed by storage.
- LATENCY, default 4, cycles from request accept to response valid; legal range 1..15.
REQ-002 Ports SHALL be:
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_be  in  4  byte-lane write enables; bit i covers bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  DATA_WIDTH  read data, or the merged word after a write.
- resp_err  out  1  address out of range.

Function
REQ-003 Storage SHALL be 2^(ADDRESS_WIDTH-2) words, indexed by req_addr[ADDRESS_WIDTH-1:2]; req_addr[1:0] is ignored.
REQ-004 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE. It is a registered state decode with no combinational dependency on req_valid.
REQ-006 In IDLE, on an edge with req_valid=1:
- the block SHALL latch req_we, req_addr, req_wdata and req_be;
- load the latency counter with LATENCY-1;
- enter BUSY.
REQ-007 In BUSY, the counter SHALL decrement each edge. At the edge where the counter is 0, the block SHALL perform the access and enter RESP.
REQ-008 Access timing: a request accepted at edge k SHALL make resp_valid 1 in the cycle after edge k+LATENCY.
REQ-009 Read access: resp_rdata SHALL be the stored word at the latched index.
REQ-010 Write access:
- only the lanes with latched be[i]=1 SHALL be updated from latched wdata;
- resp_rdata SHALL be the resulting merged word;
- be=4'b0000 changes no storage but still produces a response.
REQ-011 If latched addr[31:ADDRESS_WIDTH] is nonzero, the access SHALL be suppressed:
- no storage write;
- resp_rdata=0;
- resp_err=1.
Otherwise resp_err=0.
REQ-012 In RESP:
- resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1;
- at that edge, the FSM returns to IDLE and resp_valid=0 the next cycle.
REQ-013 A new request SHALL NOT be accepted in the cycle resp is handshaken. The minimum request-to-request period is LATENCY+2 cycles with resp_ready held at 1.
REQ-014 Request inputs SHALL be ignored outside IDLE; req_valid held high during BUSY/RESP has no effect.
REQ-015 resp_rdata and resp_err SHALL be registered outputs. They retain their last values after returning to IDLE and are only meaningful while resp_valid=1.
REQ-016 Pipeline stall or flush upstream SHALL NOT abort an accepted request. Once accepted, a request always completes unless reset.

Reset
REQ-017 RST=0 SHALL asynchronously force:
- state=IDLE, counter=0;
- resp_valid=0, resp_rdata=0, resp_err=0;
- req_ready=1 once RST=1, from the first edge after deassertion.
REQ-018 Storage contents SHALL NOT be reset. Reads of locations never written return unspecified data.
REQ-019 Reset asserted during BUSY SHALL discard the pending request; a pending write is not committed. Reset asserted during RESP SHALL drop the response.

Verification
REQ-020 Write then read (LATENCY=4): write addr 0x100, wdata 0xDEADBEEF, be 4'hF, accepted at edge 0.
- resp_valid rises after edge 4, resp_rdata=0xDEADBEEF, resp_err=0.
- A read of 0x100 then returns 0xDEADBEEF.
REQ-021 Byte-lane merge: with 0x100 holding 0xDEADBEEF, write wdata 0x11223344 with be 4'b0101.
- Response and a subsequent read both give 0xDE22BE44.
REQ-022 Backpressure: hold resp_ready=0 for 6 cycles after resp_valid rises.
- resp_valid/resp_rdata stay stable and req_ready=0 throughout.
- After resp_ready=1, req_ready returns to 1 one cycle later.
REQ-023 Out of range: write to 0x0002_0000 with ADDRESS_WIDTH=17 -> resp_err=1, resp_rdata=0. A read of 0x0000_0000 shows the write did not alias to word 0.
REQ-024 Reset mid-write: assert RST=0 two cycles after accepting a write to 0x200 of 0xCAFEF00D.
- Outputs clear immediately, with no response.
- After reset, write 0x0 with be=0 to 0x200, then read 0x200: data equals the prior contents, not 0xCAFEF00D.
REQ-025 Addr low bits: a read of 0x103 returns the same word as 0x100.
